// File: rtl/line_buffer_3row.sv
// Three-row line buffer: two line RAMs plus the live pixel give column-aligned taps for a 3x3 window stage.
// Optional build macro LINE_BUF_PAD_EN: also emit during the two fill rows, with the missing rows zeroed.
module line_buffer_3row #(
  parameter int unsigned WIDTH      = 24,
  parameter int unsigned PIC_WIDTH  = 320,
  parameter int unsigned PIC_HEIGHT = 240
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] din,
  output logic             valid_out,
  output logic [WIDTH-1:0] dout1,
  output logic [WIDTH-1:0] dout2,
  output logic [WIDTH-1:0] dout3,
  output logic             frame_end
);

  localparam int unsigned CNT_W = 9;
  localparam int unsigned AW    = (PIC_WIDTH > 1) ? $clog2(PIC_WIDTH) : 1;

  typedef enum logic [1:0] {
    S_FILL0 = 2'd0,
    S_FILL1 = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_col;
  logic [CNT_W-1:0] r_row;
  logic [CNT_W-1:0] w_col_nxt;
  logic [CNT_W-1:0] w_row_nxt;
  logic             w_col_wrap;
  logic             w_row_wrap;
  logic             w_emit;

  logic [WIDTH-1:0] r_ram_a [PIC_WIDTH];
  logic [WIDTH-1:0] r_ram_b [PIC_WIDTH];
  logic [AW-1:0]    w_addr;
  logic [WIDTH-1:0] w_rd_a;
  logic [WIDTH-1:0] w_rd_b;
  logic [WIDTH-1:0] w_tap1;
  logic [WIDTH-1:0] w_tap2;

  // Both line RAMs share the column address; reads see the pre-write contents.
  always_comb begin
    w_addr = AW'(r_col);
    w_rd_a = r_ram_a[w_addr];
    w_rd_b = r_ram_b[w_addr];
  end

  // Counters and fill/run sequencing; all wraps land on the same accepted pixel.
  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    w_col_wrap  = valid_in && (r_col == CNT_W'(PIC_WIDTH - 1));
    w_row_wrap  = w_col_wrap && (r_row == CNT_W'(PIC_HEIGHT - 1));

    if (valid_in) begin
      w_col_nxt = w_col_wrap ? '0 : r_col + CNT_W'(1);
    end
    if (w_col_wrap) begin
      w_row_nxt = w_row_wrap ? '0 : r_row + CNT_W'(1);
    end

    case (r_state)
      S_FILL0: if (w_col_wrap) w_state_nxt = S_FILL1;
      S_FILL1: if (w_col_wrap) w_state_nxt = S_RUN;
      S_RUN:   if (w_row_wrap) w_state_nxt = S_FILL0;
      default: w_state_nxt = S_FILL0;
    endcase
  end

  // Output qualification and tap selection.
  always_comb begin
`ifdef LINE_BUF_PAD_EN
    w_emit = valid_in;
    w_tap2 = (r_state == S_FILL0) ? '0 : w_rd_a;
    w_tap1 = (r_state == S_RUN)   ? w_rd_b : '0;
`else
    w_emit = valid_in && (r_state == S_RUN);
    w_tap2 = w_rd_a;
    w_tap1 = w_rd_b;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_FILL0;
      r_col     <= '0;
      r_row     <= '0;
      valid_out <= 1'b0;
      frame_end <= 1'b0;
      dout1     <= '0;
      dout2     <= '0;
      dout3     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_col     <= w_col_nxt;
      r_row     <= w_row_nxt;
      valid_out <= w_emit;
      frame_end <= w_row_wrap;
      if (valid_in) begin
        dout1 <= w_tap1;
        dout2 <= w_tap2;
        dout3 <= din;
      end
    end
  end

  // Line RAMs are never reset; the fill states hide their stale contents.
  always_ff @(posedge clk) begin
    if (valid_in) begin
      r_ram_a[w_addr] <= din;
      r_ram_b[w_addr] <= w_rd_a;
    end
  end

endmodule

// File: tb/tb_line_buffer_3row.sv
// Bench for line_buffer_3row: directed spec scenarios plus random frames against an image-array model.
module tb_line_buffer_3row;

  localparam int unsigned W  = 24;
  localparam int unsigned PW = 4;
  localparam int unsigned PH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid_in;
  logic [W-1:0] din;
  logic         valid_out;
  logic [W-1:0] dout1;
  logic [W-1:0] dout2;
  logic [W-1:0] dout3;
  logic         frame_end;

  line_buffer_3row #(.WIDTH(W), .PIC_WIDTH(PW), .PIC_HEIGHT(PH)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .din(din),
    .valid_out(valid_out), .dout1(dout1), .dout2(dout2), .dout3(dout3),
    .frame_end(frame_end)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: the current frame as an image, plus the raster position of the next pixel.
  logic [W-1:0] img [PH][PW];
  int           mr = 0;
  int           mc = 0;
  int           out_cnt;
  int           fe_cnt;
  bit           first_seen;
  logic [W-1:0] first_d1, first_d2, first_d3;
  logic [W-1:0] last_d1, last_d2, last_d3;
  bit           last_emit;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] pix);
    logic         ev, efe;
    logic [W-1:0] e1, e2;
    img[mr][mc] = pix;
    e1 = '0;
    e2 = '0;
    if (mr >= 2) e1 = img[mr-2][mc];
    if (mr >= 1) e2 = img[mr-1][mc];
`ifdef LINE_BUF_PAD_EN
    ev = 1'b1;
`else
    ev = (mr >= 2);
`endif
    efe = (mr == PH-1) && (mc == PW-1);
    valid_in = 1'b1;
    din      = pix;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    check("valid_out", 32'(valid_out), 32'(ev));
    check("frame_end", 32'(frame_end), 32'(efe));
    if (frame_end === 1'b1) fe_cnt++;
    if (ev) begin
      check("dout1", 32'(dout1), 32'(e1));
      check("dout2", 32'(dout2), 32'(e2));
      check("dout3", 32'(dout3), 32'(pix));
      out_cnt++;
      if (!first_seen) begin
        first_seen = 1'b1;
        first_d1 = e1; first_d2 = e2; first_d3 = pix;
        first_d1 = dout1; first_d2 = dout2; first_d3 = dout3;
      end
      last_d1 = dout1; last_d2 = dout2; last_d3 = dout3;
    end
    last_emit = ev;
    if (mc == PW-1) begin
      mc = 0;
      mr = (mr == PH-1) ? 0 : mr + 1;
    end else begin
      mc = mc + 1;
    end
  endtask

  task automatic idle();
    logic [W-1:0] held;
    held     = dout3;
    valid_in = 1'b0;
    din      = W'($urandom);
    @(posedge clk);
    #1;
    check("idle_valid_out", 32'(valid_out), 32'h0);
    check("idle_frame_end", 32'(frame_end), 32'h0);
    if (last_emit) check("idle_hold_dout3", 32'(dout3), 32'(last_d3));
    else           check("idle_hold_dout3_raw", 32'(dout3), 32'(held));
  endtask

  task automatic start_count();
    out_cnt    = 0;
    fe_cnt     = 0;
    first_seen = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_valid_out", 32'(valid_out), 32'h0);
    check("rst_frame_end", 32'(frame_end), 32'h0);
    check("rst_dout1", 32'(dout1), 32'h0);
    check("rst_dout2", 32'(dout2), 32'h0);
    check("rst_dout3", 32'(dout3), 32'h0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    mr        = 0;
    mc        = 0;
    last_emit = 1'b0;
  endtask

  task automatic frame(input int base, input bit toggle);
    start_count();
    for (int r = 0; r < PH; r++) begin
      for (int c = 0; c < PW; c++) begin
        push(W'(base + r*16 + c));
        if (toggle) idle();
      end
    end
  endtask

  task automatic check_frame_default_shape(input string tag, input int base);
    check({tag, "_fe_cnt"}, 32'(fe_cnt), 32'd1);
    check({tag, "_last_d1"}, 32'(last_d1), 32'(base + 32'h13));
    check({tag, "_last_d2"}, 32'(last_d2), 32'(base + 32'h23));
    check({tag, "_last_d3"}, 32'(last_d3), 32'(base + 32'h33));
`ifdef LINE_BUF_PAD_EN
    check({tag, "_out_cnt"}, 32'(out_cnt), 32'd16);
    check({tag, "_first_d1"}, 32'(first_d1), 32'h0);
    check({tag, "_first_d2"}, 32'(first_d2), 32'h0);
    check({tag, "_first_d3"}, 32'(first_d3), 32'(base));
`else
    check({tag, "_out_cnt"}, 32'(out_cnt), 32'd8);
    check({tag, "_first_d1"}, 32'(first_d1), 32'(base + 32'h00));
    check({tag, "_first_d2"}, 32'(first_d2), 32'(base + 32'h10));
    check({tag, "_first_d3"}, 32'(first_d3), 32'(base + 32'h20));
`endif
  endtask

  initial begin
    rst       = 1'b1;
    valid_in  = 1'b0;
    din       = '0;
    last_emit = 1'b0;
    #2;

    // Scenarios 1 and 2: reset then a continuous frame.
    do_reset();
    frame(0, 1'b0);
    check_frame_default_shape("s2", 0);

    // Scenario 3: valid_in toggling, same values and order.
    frame(0, 1'b1);
    check_frame_default_shape("s3", 0);

    // Scenario 4: back-to-back frames with distinct data.
    frame(0, 1'b0);
    frame(32'h100, 1'b0);
    check_frame_default_shape("s4", 32'h100);

    // Scenario 5: reset after pixel (2,0), then a clean frame.
    start_count();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < PW; c++) push(W'(32'h200 + r*16 + c));
    push(W'(32'h220));
    do_reset();
    frame(0, 1'b0);
    check_frame_default_shape("s5", 0);

    // Random pixels and random stalls, including one mid-frame reset.
    for (int f = 0; f < 4; f++) begin
      start_count();
      for (int p = 0; p < int'(PH*PW); p++) begin
        push(W'($urandom));
        if ($urandom_range(0, 2) == 0) idle();
        if (f == 1 && p == 9) begin
          do_reset();
          break;
        end
      end
      if (f != 1) begin
        check("rnd_fe_cnt", 32'(fe_cnt), 32'd1);
`ifdef LINE_BUF_PAD_EN
        check("rnd_out_cnt", 32'(out_cnt), 32'(PH*PW));
`else
        check("rnd_out_cnt", 32'(out_cnt), 32'((PH-2)*PW));
`endif
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
